// File: rtl/led_counter_gen2.sv
// Board LED pattern generator: prescaled step rate, BIN/GRAY/RING/BOUNCE patterns.
// Latency: led/tick/wrap are registered and update on the edge where a step or load occurs.
// Backpressure: none; en=0 freezes prescaler and pattern, load overrides any step.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   en                   1 = run, 0 = pause
//   mode                 00 BIN, 01 GRAY, 10 RING, 11 BOUNCE
//   dir                  0 = up/left, 1 = down/right (BOUNCE ignores it)
//   load, load_val       synchronous preload strobe and value
//   led                  registered LED pattern
//   tick                 one-clock pulse on every step
//   wrap                 one-clock pulse on counter wrap / ring wrap / bounce reversal
module led_counter_gen2 #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1,
    parameter int WIDTH   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] led,
    output logic             tick,
    output logic             wrap
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);

    localparam logic [1:0] MODE_BIN    = 2'b00;
    localparam logic [1:0] MODE_GRAY   = 2'b01;
    localparam logic [1:0] MODE_RING   = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    typedef enum logic {
        BDIR_UP = 1'b0,
        BDIR_DN = 1'b1
    } bdir_e;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] x);
        return x ^ (x >> 1);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] led_q,   led_d;
    logic             tick_q,  tick_d;
    logic             wrap_q,  wrap_d;
    bdir_e            bdir_q,  bdir_d;

    // ------------------------------------------------------------------
    // Prescaler terminal count and pattern classification
    // ------------------------------------------------------------------
    logic step;
    logic led_onehot;

    assign step = en && (presc_q == PRESC_LAST);

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign led_onehot = (led_q != '0) && ((led_q & (led_q - CNT_ONE)) == '0);

    // ------------------------------------------------------------------
    // Pattern advance for one step (used only when step is taken)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] cnt_step;
    logic [WIDTH-1:0] led_step;
    logic             wrap_step;
    bdir_e            bdir_step;
    logic [WIDTH-1:0] cnt_inc;
    logic             cnt_wraps;

    always_comb begin
        cnt_inc   = dir ? (cnt_q - CNT_ONE) : (cnt_q + CNT_ONE);
        cnt_wraps = dir ? (cnt_q == '0) : (cnt_q == CNT_MAX);

        cnt_step  = cnt_q;
        led_step  = led_q;
        wrap_step = 1'b0;
        bdir_step = bdir_q;

        case (mode)
            MODE_BIN: begin
                cnt_step  = cnt_inc;
                led_step  = cnt_inc;
                wrap_step = cnt_wraps;
            end

            MODE_GRAY: begin
                cnt_step  = cnt_inc;
                led_step  = to_gray(cnt_inc);
                wrap_step = cnt_wraps;
            end

            MODE_RING: begin
                if (!led_onehot) begin
                    // Any non-one-hot pattern (including all-zero) restarts at LSB.
                    led_step = CNT_ONE;
                end else if (!dir) begin
                    led_step  = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
                    wrap_step = led_q[WIDTH-1];
                end else begin
                    led_step  = {led_q[0], led_q[WIDTH-1:1]};
                    wrap_step = led_q[0];
                end
            end

            MODE_BOUNCE: begin
                if (!led_onehot) begin
                    led_step  = CNT_ONE;
                    bdir_step = BDIR_UP;
                end else if (bdir_q == BDIR_UP) begin
                    if (led_q[WIDTH-1]) begin
                        // Reverse at the top: the next position is one below MSB.
                        led_step  = led_q >> 1;
                        bdir_step = BDIR_DN;
                        wrap_step = 1'b1;
                    end else begin
                        led_step = led_q << 1;
                    end
                end else begin
                    if (led_q[0]) begin
                        led_step  = led_q << 1;
                        bdir_step = BDIR_UP;
                        wrap_step = 1'b1;
                    end else begin
                        led_step = led_q >> 1;
                    end
                end
            end

            default: begin
                cnt_step = cnt_q;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next state: load > step > hold (reset handled in the register)
    // ------------------------------------------------------------------
    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        led_d   = led_q;
        bdir_d  = bdir_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;

        if (load) begin
            // Load also restarts the prescaler so the next step is a full period away.
            presc_d = '0;
            cnt_d   = load_val;
            led_d   = (mode == MODE_GRAY) ? to_gray(load_val) : load_val;
            bdir_d  = BDIR_UP;
        end else if (step) begin
            presc_d = '0;
            cnt_d   = cnt_step;
            led_d   = led_step;
            bdir_d  = bdir_step;
            tick_d  = 1'b1;
            wrap_d  = wrap_step;
        end else if (en) begin
            presc_d = presc_q + PRESC_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
            led_q   <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            bdir_q  <= BDIR_UP;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            bdir_q  <= bdir_d;
        end
    end

    assign led  = led_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_led_counter_gen2.sv
module tb_led_counter_gen2;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       dir;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] led;
    logic       tick;
    logic       wrap;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [3:0] led;
        logic       wrap;
    } exp_t;

    exp_t exp_q[$];

    led_counter_gen2 #(
        .CLK_HZ (4),
        .TICK_HZ(1),
        .WIDTH  (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .dir     (dir),
        .load    (load),
        .load_val(load_val),
        .led     (led),
        .tick    (tick),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic clk1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; en = 1'b0; load = 1'b0; load_val = '0; mode = 2'b00; dir = 1'b0;
        clk1();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        rst_n = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'd5; mode = 2'b01; dir = 1'b1;
        clk1();
        n_vec++;
        if ({led, tick, wrap} !== 6'b0000_0_0) begin
            n_err++;
            $display("FAIL reset_state: led=%b tick=%b wrap=%b, want led=0000 tick=0 wrap=0", led, tick, wrap);
        end
        rst_n = 1'b1; load = 1'b0; en = 1'b0;
        clk1();
        n_vec++;
        if ({led, tick, wrap} !== 6'b0000_0_0) begin
            n_err++;
            $display("FAIL reset_hold_en0: led=%b tick=%b wrap=%b, want all zero", led, tick, wrap);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_bin_up;
        int   cyc, last;
        exp_t e;
        do_reset();
        mode = 2'b00; dir = 1'b0; en = 1'b1;
        for (int i = 1; i <= 17; i++) exp_q.push_back({4'(i), (i == 16)});
        cyc = 0; last = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            clk1();
            cyc++;
            if (tick === 1'b1) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({led, wrap} !== e) begin
                    n_err++;
                    $display("FAIL bin_up_step: led=%b wrap=%b, want led=%b wrap=%b", led, wrap, e.led, e.wrap);
                end
                n_vec++;
                if (cyc - last != 4) begin
                    n_err++;
                    $display("FAIL bin_up_tick_gap: gap=%0d clocks, want 4", cyc - last);
                end
                last = cyc;
            end else begin
                n_vec++;
                if (wrap !== 1'b0) begin
                    n_err++;
                    $display("FAIL bin_up_wrap_idle: wrap=%b without tick, want 0", wrap);
                end
            end
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bin_up_timeout: %0d steps missing, want 0", exp_q.size());
        end
        en = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // BIN down, GRAY up and BOUNCE sequences from reset.
    task automatic test_modes;
        int   cyc;
        exp_t e;
        for (int s = 0; s < 3; s++) begin
            do_reset();
            case (s)
                0: begin
                    mode = 2'b00; dir = 1'b1;
                    exp_q.push_back({4'd15, 1'b1});
                    exp_q.push_back({4'd14, 1'b0});
                    exp_q.push_back({4'd13, 1'b0});
                end
                1: begin
                    mode = 2'b01; dir = 1'b0;
                    exp_q.push_back({4'b0001, 1'b0});
                    exp_q.push_back({4'b0011, 1'b0});
                    exp_q.push_back({4'b0010, 1'b0});
                    exp_q.push_back({4'b0110, 1'b0});
                    exp_q.push_back({4'b0111, 1'b0});
                end
                default: begin
                    mode = 2'b11; dir = 1'b1;
                    exp_q.push_back({4'b0001, 1'b0});
                    exp_q.push_back({4'b0010, 1'b0});
                    exp_q.push_back({4'b0100, 1'b0});
                    exp_q.push_back({4'b1000, 1'b0});
                    exp_q.push_back({4'b0100, 1'b1});
                    exp_q.push_back({4'b0010, 1'b0});
                    exp_q.push_back({4'b0001, 1'b0});
                    exp_q.push_back({4'b0010, 1'b1});
                end
            endcase
            en = 1'b1;
            cyc = 0;
            while (exp_q.size() > 0 && cyc < 100) begin
                clk1();
                cyc++;
                if (tick === 1'b1) begin
                    e = exp_q.pop_front();
                    n_vec++;
                    if ({led, wrap} !== e) begin
                        n_err++;
                        $display("FAIL mode_seq%0d: led=%b wrap=%b, want led=%b wrap=%b", s, led, wrap, e.led, e.wrap);
                    end
                end
            end
            n_vec++;
            if (exp_q.size() != 0) begin
                n_err++;
                $display("FAIL mode_seq%0d_timeout: %0d steps missing, want 0", s, exp_q.size());
            end
            en = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------
    // Non-one-hot normalisation, left/right wrap, then resume BIN from held cnt.
    task automatic test_ring;
        int   cyc;
        exp_t e;
        do_reset();
        mode = 2'b10; dir = 1'b0;
        load = 1'b1; load_val = 4'b0110;
        clk1();
        load = 1'b0;
        n_vec++;
        if (led !== 4'b0110 || tick !== 1'b0) begin
            n_err++;
            $display("FAIL ring_load_en0: led=%b tick=%b, want led=0110 tick=0", led, tick);
        end
        exp_q.push_back({4'b0001, 1'b0});
        exp_q.push_back({4'b0010, 1'b0});
        exp_q.push_back({4'b0100, 1'b0});
        exp_q.push_back({4'b1000, 1'b0});
        exp_q.push_back({4'b0001, 1'b1});
        exp_q.push_back({4'b1000, 1'b1});
        exp_q.push_back({4'b0100, 1'b0});
        exp_q.push_back({4'd7,    1'b0});
        en = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            clk1();
            cyc++;
            if (tick === 1'b1) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({led, wrap} !== e) begin
                    n_err++;
                    $display("FAIL ring_step: led=%b wrap=%b, want led=%b wrap=%b", led, wrap, e.led, e.wrap);
                end
                if (exp_q.size() == 3) dir = 1'b1;
                if (exp_q.size() == 1) begin
                    mode = 2'b00; dir = 1'b0;
                end
            end
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL ring_timeout: %0d steps missing, want 0", exp_q.size());
        end
        en = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_load_pause;
        exp_t e;
        do_reset();
        mode = 2'b00; dir = 1'b0; en = 1'b1;
        clk1();
        clk1();
        load = 1'b1; load_val = 4'd9;
        clk1();
        load = 1'b0;
        n_vec++;
        if (led !== 4'd9 || tick !== 1'b0 || wrap !== 1'b0) begin
            n_err++;
            $display("FAIL load_mid: led=%0d tick=%b wrap=%b, want led=9 tick=0 wrap=0", led, tick, wrap);
        end
        exp_q.push_back({4'd10, 1'b0});
        for (int k = 1; k <= 4; k++) begin
            clk1();
            n_vec++;
            if (tick !== (k == 4)) begin
                n_err++;
                $display("FAIL load_next_tick: clk %0d tick=%b, want %b", k, tick, (k == 4));
            end
            if (k == 4 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({led, wrap} !== e) begin
                    n_err++;
                    $display("FAIL load_step: led=%0d wrap=%b, want led=%0d wrap=%b", led, wrap, e.led, e.wrap);
                end
            end
        end
        // Pause with the prescaler mid-count.
        clk1();
        clk1();
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            clk1();
            n_vec++;
            if (led !== 4'd10 || tick !== 1'b0 || wrap !== 1'b0) begin
                n_err++;
                $display("FAIL pause_hold: clk %0d led=%0d tick=%b wrap=%b, want led=10 tick=0 wrap=0", k, led, tick, wrap);
            end
        end
        en = 1'b1;
        exp_q.push_back({4'd11, 1'b0});
        for (int k = 1; k <= 2; k++) begin
            clk1();
            n_vec++;
            if (tick !== (k == 2)) begin
                n_err++;
                $display("FAIL pause_resume_tick: clk %0d tick=%b, want %b", k, tick, (k == 2));
            end
            if (k == 2 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({led, wrap} !== e) begin
                    n_err++;
                    $display("FAIL pause_resume_step: led=%0d wrap=%b, want led=%0d wrap=%b", led, wrap, e.led, e.wrap);
                end
            end
        end
        // Load in GRAY mode while paused shows the Gray code of load_val.
        en = 1'b0; mode = 2'b01;
        load = 1'b1; load_val = 4'd3;
        clk1();
        load = 1'b0;
        n_vec++;
        if (led !== 4'b0010) begin
            n_err++;
            $display("FAIL gray_load_en0: led=%b, want 0010", led);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid;
        do_reset();
        mode = 2'b10; dir = 1'b0;
        load = 1'b1; load_val = 4'b1000;
        clk1();
        load = 1'b0; en = 1'b1;
        clk1(); clk1(); clk1();
        n_vec++;
        if (led !== 4'b1000 || tick !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_pre: led=%b tick=%b, want led=1000 tick=0", led, tick);
        end
        rst_n = 1'b0; load = 1'b1; load_val = 4'd5;
        clk1();
        n_vec++;
        if ({led, tick, wrap} !== 6'b0000_0_0) begin
            n_err++;
            $display("FAIL rst_mid: led=%b tick=%b wrap=%b, want led=0000 tick=0 wrap=0", led, tick, wrap);
        end
        rst_n = 1'b1; load = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            clk1();
            n_vec++;
            if (tick !== (k == 4)) begin
                n_err++;
                $display("FAIL rst_mid_presc: clk %0d tick=%b, want %b", k, tick, (k == 4));
            end
        end
        n_vec++;
        if (led !== 4'b0001 || wrap !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_ring_norm: led=%b wrap=%b, want led=0001 wrap=0", led, wrap);
        end
        en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; dir = 1'b0; load = 1'b0; load_val = '0;
        test_reset();
        test_bin_up();
        test_modes();
        test_ring();
        test_load_pause();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
